// File: rtl/lif_seq_pkg.sv
// Shared definitions for the LIF/PWM tile setup sequencer: opcodes, header
// field widths and the sequencer state encoding.
package lif_seq_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned LEN_W = 5;

    localparam logic [OP_W-1:0] OP_INPUTS    = 3'b000;
    localparam logic [OP_W-1:0] OP_WEIGHTS   = 3'b001;
    localparam logic [OP_W-1:0] OP_THRESHOLD = 3'b010;
    localparam logic [OP_W-1:0] OP_BIAS      = 3'b011;
    localparam logic [OP_W-1:0] OP_SHIFT     = 3'b100;
    localparam logic [OP_W-1:0] OP_STREAM    = 3'b101;
    localparam logic [OP_W-1:0] OP_BATCHNORM = 3'b110;
    localparam logic [OP_W-1:0] OP_RUN       = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_EXEC,
        S_DRAIN
    } state_e;

    // Streaming mode is never emitted by this sequencer, so it is not a setup op.
    function automatic logic is_setup_op(input logic [OP_W-1:0] op);
        case (op)
            OP_INPUTS, OP_WEIGHTS, OP_THRESHOLD,
            OP_BIAS, OP_SHIFT, OP_BATCHNORM: return 1'b1;
            OP_STREAM, OP_RUN:               return 1'b0;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lif_seq_spike_counter.sv
// Counts tile spikes during a RUN: spike_in is sampled one cycle after each
// execute cycle into an 8-bit saturating counter, cleared when a RUN starts.
module lif_seq_spike_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       abort,
    input  logic       start,
    input  logic       execute,
    input  logic       spike_in,
    output logic [7:0] spike_count
);

    logic       smp_q, smp_d;
    logic [7:0] count_q, count_d;

    always_comb begin
        smp_d   = execute & ~abort;
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (smp_q && spike_in && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            smp_q   <= 1'b0;
            count_q <= '0;
        end else begin
            smp_q   <= smp_d;
            count_q <= count_d;
        end
    end

    assign spike_count = count_q;

endmodule

// File: rtl/lif_setup_sequencer.sv
// Byte-command sequencer driving the neuron tile setup bus and execute enable.
// Define LIF_SEQ_SPIKE_COUNT_EN to include the RUN spike counter.
module lif_setup_sequencer
    import lif_seq_pkg::*;
#(
    parameter int unsigned SYNC_HIGH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       abort,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] setup_data,
    output logic [2:0] setup_control,
    output logic       setup_sync,
    output logic       execute,
    input  logic       spike_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] spike_count
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       stb_q, stb_d;
    logic [7:0]       setup_data_q, setup_data_d;
    logic [2:0]       setup_control_q, setup_control_d;
    logic             setup_sync_q, setup_sync_d;
    logic             execute_q, execute_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             accept;
    logic [OP_W-1:0]  hdr_op;
    logic [LEN_W-1:0] hdr_len;

    // Abort masks acceptance so a byte offered alongside it is never consumed.
    assign accept  = cmd_valid & cmd_ready_q & ~abort;
    assign hdr_op  = cmd_data[7:5];
    assign hdr_len = cmd_data[4:0];

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        cnt_d           = cnt_q;
        stb_d           = stb_q;
        setup_data_d    = setup_data_q;
        setup_control_d = setup_control_q;
        setup_sync_d    = setup_sync_q;
        execute_d       = execute_q;
        cmd_ready_d     = cmd_ready_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        error_d         = error_q;

        if (abort) begin
            state_d         = S_IDLE;
            op_d            = '0;
            cnt_d           = '0;
            stb_d           = '0;
            setup_data_d    = '0;
            setup_control_d = '0;
            setup_sync_d    = 1'b0;
            execute_d       = 1'b0;
            cmd_ready_d     = 1'b1;
            busy_d          = 1'b0;
            error_d         = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    if (hdr_op == OP_RUN) begin
                        cnt_d       = hdr_len;
                        state_d     = S_EXEC;
                        execute_d   = 1'b1;
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                    end else if (is_setup_op(hdr_op)) begin
                        op_d    = hdr_op;
                        cnt_d   = hdr_len;
                        state_d = S_WAIT;
                        busy_d  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                S_WAIT: if (accept) begin
                    setup_data_d    = cmd_data;
                    setup_control_d = op_q;
                    cmd_ready_d     = 1'b0;
                    state_d         = S_SETUP;
                end
                S_SETUP: begin
                    state_d      = S_STROBE;
                    setup_sync_d = 1'b1;
                    stb_d        = 2'(SYNC_HIGH - 1);
                end
                S_STROBE: begin
                    if (stb_q == '0) begin
                        state_d      = S_HOLD;
                        setup_sync_d = 1'b0;
                    end else begin
                        stb_d = stb_q - 2'd1;
                    end
                end
                S_HOLD: begin
                    cmd_ready_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d         = S_IDLE;
                        setup_data_d    = '0;
                        setup_control_d = '0;
                        busy_d          = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - 5'd1;
                        state_d = S_WAIT;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        state_d   = S_DRAIN;
                        execute_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                S_DRAIN: begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
                default: begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            op_q            <= '0;
            cnt_q           <= '0;
            stb_q           <= '0;
            setup_data_q    <= '0;
            setup_control_q <= '0;
            setup_sync_q    <= 1'b0;
            execute_q       <= 1'b0;
            cmd_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            cnt_q           <= cnt_d;
            stb_q           <= stb_d;
            setup_data_q    <= setup_data_d;
            setup_control_q <= setup_control_d;
            setup_sync_q    <= setup_sync_d;
            execute_q       <= execute_d;
            cmd_ready_q     <= cmd_ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign setup_data    = setup_data_q;
    assign setup_control = setup_control_q;
    assign setup_sync    = setup_sync_q;
    assign execute       = execute_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

`ifdef LIF_SEQ_SPIKE_COUNT_EN
    logic run_start;
    assign run_start = accept && (state_q == S_IDLE) && (hdr_op == OP_RUN);

    lif_seq_spike_counter u_spike_counter (
        .clk         (clk),
        .reset       (reset),
        .abort       (abort),
        .start       (run_start),
        .execute     (execute_q),
        .spike_in    (spike_in),
        .spike_count (spike_count)
    );
`else
    logic unused_spike_in;
    assign unused_spike_in = spike_in;
    assign spike_count     = '0;
`endif

endmodule

// File: tb/tb_lif_setup_sequencer.sv
// Randomized bench for lif_setup_sequencer against a cycle-offset timing model.
module tb_lif_setup_sequencer;

    localparam int unsigned SH = 3;
    localparam logic [16:0] WAIT_MASK = 17'h1C007;
    localparam logic [16:0] IDLE_VEC  = 17'h10000;

    logic       clk = 1'b0;
    logic       reset, abort, cmd_valid, spike_in;
    logic [7:0] cmd_data;
    logic       cmd_ready, setup_sync, execute, busy, done, error;
    logic [7:0] setup_data, spike_count;
    logic [2:0] setup_control;

    lif_setup_sequencer #(.SYNC_HIGH(SH)) dut (
        .clk           (clk),
        .reset         (reset),
        .abort         (abort),
        .cmd_data      (cmd_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .setup_data    (setup_data),
        .setup_control (setup_control),
        .setup_sync    (setup_sync),
        .execute       (execute),
        .spike_in      (spike_in),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .spike_count   (spike_count)
    );

    always #5 clk = ~clk;

    // {ready, busy, sync, control[2:0], data[7:0], execute, done, error}
    logic [16:0] obs;
    assign obs = {cmd_ready, busy, setup_sync, setup_control, setup_data, execute, done, error};

    int unsigned n_pass = 0, n_total = 0;
    logic        exp_err = 1'b0;
    logic [7:0]  exp_sc = '0;
    logic        sc_known = 1'b1;
    logic [7:0]  pay_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left in an IDLE cycle with the header driven in the entry cycle.
    task automatic run_setup(input logic [2:0] op, input int unsigned nbytes, input int unsigned maxgap);
        logic [7:0]  b;
        logic [16:0] e, m;
        int unsigned g;
        cmd_data  = {op, 5'(nbytes - 1)};
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int unsigned i = 0; i < nbytes; i++) begin
            g = $urandom_range(maxgap, 0);
            for (int unsigned j = 0; j <= g; j++) begin
                e = {1'b1, 1'b1, 1'b0, 3'b0, 8'b0, 1'b0, 1'b0, exp_err};
                n_total++;
                if ((obs & WAIT_MASK) !== (e & WAIT_MASK))
                    $display("FAIL setup_wait byte=%0d got=%h exp=%h", i, obs & WAIT_MASK, e & WAIT_MASK);
                else n_pass++;
                if (j < g) begin
                    cmd_valid = 1'b0;
                    tick();
                end
            end
            b = (pay_q.size() != 0) ? pay_q.pop_front() : 8'($urandom);
            cmd_data  = b;
            cmd_valid = 1'b1;
            tick();
            cmd_data = 8'h01;
            for (int unsigned k = 1; k <= 3 + SH; k++) begin
                m = '1;
                if (k == 1)
                    e = {1'b0, 1'b1, 1'b0, op, b, 1'b0, 1'b0, exp_err};
                else if (k <= 1 + SH)
                    e = {1'b0, 1'b1, 1'b1, op, b, 1'b0, 1'b0, exp_err};
                else if (k == 2 + SH)
                    e = {1'b0, 1'b1, 1'b0, op, b, 1'b0, 1'b0, exp_err};
                else if (i == nbytes - 1)
                    e = {IDLE_VEC[16:1], exp_err};
                else begin
                    e = {1'b1, 1'b1, 1'b0, 3'b0, 8'b0, 1'b0, 1'b0, exp_err};
                    m = WAIT_MASK;
                end
                n_total++;
                if ((obs & m) !== (e & m))
                    $display("FAIL setup_seq op=%0d byte=%0d k=%0d got=%h exp=%h", op, i, k, obs & m, e & m);
                else n_pass++;
                if (k < 3 + SH) tick();
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input int unsigned len, input logic [31:0] smask, input int unsigned abort_at);
        logic [16:0] e, m;
        int unsigned cnt = 0;
        if (sc_known) begin
            n_total++;
            if (spike_count !== exp_sc)
                $display("FAIL spike_count_stable got=%0d exp=%0d", spike_count, exp_sc);
            else n_pass++;
        end
        cmd_data  = {3'b111, 5'(len)};
        cmd_valid = 1'b1;
        spike_in  = 1'($urandom);
        tick();
        cmd_valid = 1'b0;
        for (int unsigned k = 1; k <= len + 3; k++) begin
            e = {1'(k == len + 3), 1'(k <= len + 2), 1'b0, 3'b0, 8'b0, 1'(k <= len + 1), 1'(k == len + 3), exp_err};
            m = (k == len + 3) ? 17'h1FFFF : WAIT_MASK;
            n_total++;
            if ((obs & m) !== (e & m))
                $display("FAIL run_seq len=%0d k=%0d got=%h exp=%h", len, k, obs & m, e & m);
            else n_pass++;
            if (k == 1 || k == len + 3) begin
`ifdef LIF_SEQ_SPIKE_COUNT_EN
                exp_sc = (k == 1) ? 8'd0 : 8'(cnt);
`else
                exp_sc = 8'd0;
`endif
                n_total++;
                if (spike_count !== exp_sc)
                    $display("FAIL spike_count len=%0d k=%0d got=%0d exp=%0d", len, k, spike_count, exp_sc);
                else n_pass++;
            end
            if (k == abort_at) begin
                abort = 1'b1;
                tick();
                abort    = 1'b0;
                spike_in = 1'b0;
                exp_err  = 1'b0;
                sc_known = 1'b0;
                for (int unsigned j = 0; j < 3; j++) begin
                    n_total++;
                    if (obs !== IDLE_VEC)
                        $display("FAIL run_abort j=%0d got=%h exp=%h", j, obs, IDLE_VEC);
                    else n_pass++;
                    if (j < 2) tick();
                end
                return;
            end
            if (k < len + 3) begin
                spike_in = (k >= 2) ? smask[k - 2] : 1'($urandom);
                if (k >= 2 && spike_in && cnt < 255) cnt++;
                tick();
            end
        end
        spike_in = 1'b0;
        sc_known = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; abort = 1'b0; cmd_valid = 1'b0; cmd_data = '0; spike_in = 1'b0;
        tick();
        tick();
        n_total++;
        if (obs !== IDLE_VEC || spike_count !== 8'd0)
            $display("FAIL reset_state got=%h/%0d exp=%h/0", obs, spike_count, IDLE_VEC);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_total++;
        if (obs !== IDLE_VEC)
            $display("FAIL post_reset got=%h exp=%h", obs, IDLE_VEC);
        else n_pass++;
        exp_err = 1'b0; exp_sc = '0; sc_known = 1'b1;
    endtask

    task automatic test_directed();
        pay_q = {8'hAA, 8'h55};
        run_setup(3'b001, 2, 0);
        pay_q = {8'h07};
        run_setup(3'b010, 1, 1);
        run_cmd(4, 32'b10101, 0);
    endtask

    task automatic test_illegal();
        cmd_data  = {3'b101, 5'($urandom)};
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        exp_err   = 1'b1;
        for (int unsigned j = 0; j < 3; j++) begin
            n_total++;
            if (obs !== {IDLE_VEC[16:1], 1'b1})
                $display("FAIL illegal_op j=%0d got=%h exp=%h", j, obs, {IDLE_VEC[16:1], 1'b1});
            else n_pass++;
            if (j < 2) tick();
        end
        run_setup(3'b110, 2, 2);
        abort = 1'b1;
        tick();
        abort   = 1'b0;
        exp_err = 1'b0;
        n_total++;
        if (obs !== IDLE_VEC)
            $display("FAIL abort_clears_error got=%h exp=%h", obs, IDLE_VEC);
        else n_pass++;
    endtask

    task automatic test_abort();
        abort = 1'b1; cmd_valid = 1'b1; cmd_data = 8'hE4;
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
        for (int unsigned j = 0; j < 2; j++) begin
            n_total++;
            if (obs !== IDLE_VEC)
                $display("FAIL abort_wins j=%0d got=%h exp=%h", j, obs, IDLE_VEC);
            else n_pass++;
            tick();
        end
        run_cmd(31, $urandom, 10);
        cmd_data = 8'h61; cmd_valid = 1'b1;
        tick();
        cmd_data = 8'h3C;
        tick();
        cmd_data = 8'h01;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
        n_total++;
        if (obs !== IDLE_VEC)
            $display("FAIL setup_abort got=%h exp=%h", obs, IDLE_VEC);
        else n_pass++;
        cmd_data = 8'h8A; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++;
        if (obs !== IDLE_VEC || spike_count !== 8'd0)
            $display("FAIL reset_mid_seq got=%h/%0d exp=%h/0", obs, spike_count, IDLE_VEC);
        else n_pass++;
        exp_sc = '0; sc_known = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        for (int unsigned n = 0; n < 24; n++) begin
            if ($urandom_range(2, 0) != 0) begin
                op = 3'($urandom_range(5, 0));
                if (op == 3'd5) op = 3'd6;
                run_setup(op, $urandom_range(3, 1), $urandom_range(2, 0));
            end else begin
                run_cmd((n % 7 == 3) ? 31 : $urandom_range(7, 0), $urandom, 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
